// File: rtl/spu_result_fwd_pipe.sv
// -----------------------------------------------------------------------------
// spu_result_fwd_pipe
//
// Result staging and forwarding pipe shared by all SPU issue lanes. Every lane
// pushes at most one result per cycle. A result ages through DEPTH stages and
// writes back to the register file from the last stage. Each lane's source
// operands are matched against every lane and stage, so a consumer can take a
// result before it reaches the register file.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   stall         freeze every stage; inputs ignored, no writeback
//   flush         kill entries leaving stage 1 (branch redirect)
//   in_valid/in_wr/in_dst/in_lat/in_data   per-lane result push
//   src_addr      NUM_LANES*NUM_SRC operand addresses (lane-major)
//   fwd_hit       youngest match is ready; fwd_data carries its value
//   fwd_pending   youngest match is still in flight and not yet ready
//   fwd_data      forwarded value (0 unless fwd_hit)
//   wb_en/wb_addr/wb_data   registered RF write port per lane
//
// Build option
//   SPU_FWD_PENDING_CHECK_EN  defined: readiness tracked, fwd_pending active.
//                             undefined: fwd_pending = 0 and every valid write
//                             match is forwarded as a hit (the issue logic
//                             guarantees the latency gap in that build).
// -----------------------------------------------------------------------------
module spu_result_fwd_pipe #(
  parameter int NUM_LANES = 2,
  parameter int NUM_SRC   = 3,
  parameter int DEPTH     = 7,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7,
  parameter int LAT_W     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall,
  input  logic                                 flush,
  input  logic [NUM_LANES-1:0]                 in_valid,
  input  logic [NUM_LANES-1:0]                 in_wr,
  input  logic [NUM_LANES*ADDR_W-1:0]          in_dst,
  input  logic [NUM_LANES*LAT_W-1:0]           in_lat,
  input  logic [NUM_LANES*DATA_W-1:0]          in_data,
  input  logic [NUM_LANES*NUM_SRC*ADDR_W-1:0]  src_addr,
  output logic [NUM_LANES*NUM_SRC-1:0]         fwd_hit,
  output logic [NUM_LANES*NUM_SRC-1:0]         fwd_pending,
  output logic [NUM_LANES*NUM_SRC*DATA_W-1:0]  fwd_data,
  output logic [NUM_LANES-1:0]                 wb_en,
  output logic [NUM_LANES*ADDR_W-1:0]          wb_addr,
  output logic [NUM_LANES*DATA_W-1:0]          wb_data
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] dst;
    logic [LAT_W-1:0]  lat;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Index [l][s] holds lane l, stage s+1.
  entry_t stage_q [NUM_LANES][DEPTH];
  entry_t stage_d [NUM_LANES][DEPTH];

  logic [NUM_LANES-1:0]        wb_en_q,   wb_en_d;
  logic [NUM_LANES*ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [NUM_LANES*DATA_W-1:0] wb_data_q, wb_data_d;

  // Latency is stored already clamped to 1..DEPTH so the ready test is a
  // plain compare against the stage number.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0)
      return LAT_W'(1);
    else if (int'(lat) > DEPTH)
      return LAT_W'(DEPTH);
    else
      return lat;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage advance and writeback staging
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_d[l][s] = stage_q[l][s];
      end
    end

    if (!stall) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        stage_d[l][0].valid = in_valid[l];
        stage_d[l][0].wr    = in_wr[l];
        stage_d[l][0].dst   = in_dst[l*ADDR_W +: ADDR_W];
        stage_d[l][0].lat   = clamp_lat(in_lat[l*LAT_W +: LAT_W]);
        stage_d[l][0].data  = in_data[l*DATA_W +: DATA_W];
        for (int s = 1; s < DEPTH; s++) begin
          stage_d[l][s] = stage_q[l][s-1];
          // A redirect only kills the youngest already-staged results; the
          // push arriving this cycle belongs to the new path.
          if (s == 1 && flush) begin
            stage_d[l][s].valid = 1'b0;
          end
        end
      end
    end

    // The writeback port is registered from the value the last stage is about
    // to take, so wb_* mirrors stage DEPTH without a path from the inputs.
    // A stalled edge clears wb_en; the held entry already wrote when it
    // arrived, so each entry writes back exactly once.
    wb_en_d   = '0;
    wb_addr_d = '0;
    wb_data_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      wb_en_d[l]                     = !stall && stage_d[l][DEPTH-1].valid
                                              && stage_d[l][DEPTH-1].wr;
      wb_addr_d[l*ADDR_W +: ADDR_W]  = stage_d[l][DEPTH-1].dst;
      wb_data_d[l*DATA_W +: DATA_W]  = stage_d[l][DEPTH-1].data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int s = 0; s < DEPTH; s++) begin
          stage_q[l][s] <= '0;
        end
      end
      wb_en_q   <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int s = 0; s < DEPTH; s++) begin
          stage_q[l][s] <= stage_d[l][s];
        end
      end
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

  // ---------------------------------------------------------------------------
  // Forwarding lookup
  // Scan from the oldest stage to the youngest and from lane 0 upward; the
  // last match written wins, which gives youngest stage first, then highest
  // lane within a stage (program order inside one issue cycle).
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_hit     = '0;
    fwd_pending = '0;
    fwd_data    = '0;
    for (int q = 0; q < NUM_LANES; q++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        automatic int                idx   = q*NUM_SRC + j;
        automatic logic [ADDR_W-1:0] addr  = src_addr[idx*ADDR_W +: ADDR_W];
        automatic logic              found = 1'b0;
        automatic logic [DATA_W-1:0] val   = '0;
`ifdef SPU_FWD_PENDING_CHECK_EN
        automatic logic              ready = 1'b0;
`endif
        for (int s = DEPTH-1; s >= 0; s--) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (stage_q[l][s].valid && stage_q[l][s].wr &&
                stage_q[l][s].dst == addr) begin
              found = 1'b1;
              val   = stage_q[l][s].data;
`ifdef SPU_FWD_PENDING_CHECK_EN
              ready = (int'(stage_q[l][s].lat) <= s + 1);
`endif
            end
          end
        end
`ifdef SPU_FWD_PENDING_CHECK_EN
        // A younger unready producer shadows any older ready one: the older
        // value is stale for this consumer.
        fwd_hit[idx]     = found && ready;
        fwd_pending[idx] = found && !ready;
        fwd_data[idx*DATA_W +: DATA_W] = (found && ready) ? val : '0;
`else
        fwd_hit[idx]     = found;
        fwd_pending[idx] = 1'b0;
        fwd_data[idx*DATA_W +: DATA_W] = found ? val : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spu_result_fwd_pipe.sv
module tb_spu_result_fwd_pipe;

  localparam int NL  = 2;
  localparam int NS  = 3;
  localparam int DEP = 7;
  localparam int DW  = 128;
  localparam int AW  = 7;
  localparam int LW  = 4;

`ifdef SPU_FWD_PENDING_CHECK_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall;
  logic                 flush;
  logic [NL-1:0]        in_valid;
  logic [NL-1:0]        in_wr;
  logic [NL*AW-1:0]     in_dst;
  logic [NL*LW-1:0]     in_lat;
  logic [NL*DW-1:0]     in_data;
  logic [NL*NS*AW-1:0]  src_addr;
  logic [NL*NS-1:0]     fwd_hit;
  logic [NL*NS-1:0]     fwd_pending;
  logic [NL*NS*DW-1:0]  fwd_data;
  logic [NL-1:0]        wb_en;
  logic [NL*AW-1:0]     wb_addr;
  logic [NL*DW-1:0]     wb_data;

  spu_result_fwd_pipe #(
    .NUM_LANES(NL), .NUM_SRC(NS), .DEPTH(DEP),
    .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wr(in_wr), .in_dst(in_dst), .in_lat(in_lat),
    .in_data(in_data), .src_addr(src_addr),
    .fwd_hit(fwd_hit), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bench-side stimulus
  bit             v   [NL];
  bit             w   [NL];
  logic [AW-1:0]  d   [NL];
  logic [LW-1:0]  lt  [NL];
  logic [DW-1:0]  dat [NL];
  logic [AW-1:0]  src [NL][NS];

  task automatic idle_inputs();
    stall = 1'b0;
    flush = 1'b0;
    for (int l = 0; l < NL; l++) begin
      v[l] = 0; w[l] = 0; d[l] = '0; lt[l] = '0; dat[l] = '0;
      for (int j = 0; j < NS; j++) src[l][j] = '0;
    end
  endtask

  task automatic apply();
    for (int l = 0; l < NL; l++) begin
      in_valid[l]            = v[l];
      in_wr[l]               = w[l];
      in_dst[l*AW +: AW]     = d[l];
      in_lat[l*LW +: LW]     = lt[l];
      in_data[l*DW +: DW]    = dat[l];
      for (int j = 0; j < NS; j++) src_addr[(l*NS+j)*AW +: AW] = src[l][j];
    end
  endtask

  task automatic push(input int l, input logic [AW-1:0] dst, input int lat,
                      input logic [DW-1:0] value);
    v[l] = 1; w[l] = 1; d[l] = dst; lt[l] = LW'(lat); dat[l] = value;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a list of in-flight results, each with its age in cycles
  // since it was pushed. Ages advance only on non-stalled edges.
  // ---------------------------------------------------------------------------
  typedef struct {
    int            lane;
    bit            wr;
    logic [AW-1:0] dst;
    int            lat;
    logic [DW-1:0] data;
    int            age;
  } ment_t;

  ment_t          inflight[$];
  bit             exp_wb_en   [NL];
  logic [AW-1:0]  exp_wb_addr [NL];
  logic [DW-1:0]  exp_wb_data [NL];

  function automatic int eff_lat(input int raw);
    if (raw < 1)   return 1;
    if (raw > DEP) return DEP;
    return raw;
  endfunction

  task automatic model_reset();
    inflight.delete();
    for (int l = 0; l < NL; l++) exp_wb_en[l] = 0;
  endtask

  task automatic model_step();
    ment_t kept[$];
    for (int l = 0; l < NL; l++) exp_wb_en[l] = 0;
    if (stall) return;
    foreach (inflight[i]) begin
      if (flush && inflight[i].age == 1) continue;
      if (inflight[i].age + 1 > DEP) continue;
      kept.push_back(inflight[i]);
      kept[kept.size()-1].age = inflight[i].age + 1;
    end
    for (int l = 0; l < NL; l++) begin
      if (v[l]) begin
        ment_t e;
        e.lane = l; e.wr = w[l]; e.dst = d[l]; e.lat = eff_lat(int'(lt[l]));
        e.data = dat[l]; e.age = 1;
        kept.push_back(e);
      end
    end
    inflight = kept;
    foreach (inflight[i]) begin
      if (inflight[i].age == DEP && inflight[i].wr) begin
        exp_wb_en[inflight[i].lane]   = 1;
        exp_wb_addr[inflight[i].lane] = inflight[i].dst;
        exp_wb_data[inflight[i].lane] = inflight[i].data;
      end
    end
  endtask

  task automatic model_lookup(input logic [AW-1:0] a, output bit hit,
                              output bit pend, output logic [DW-1:0] val);
    int best = -1;
    hit = 0; pend = 0; val = '0;
    foreach (inflight[i]) begin
      if (inflight[i].wr && inflight[i].dst == a) begin
        if (best < 0 || inflight[i].age < inflight[best].age ||
            (inflight[i].age == inflight[best].age &&
             inflight[i].lane > inflight[best].lane))
          best = i;
      end
    end
    if (best >= 0) begin
      if (!PEND_EN || inflight[best].age >= inflight[best].lat) begin
        hit = 1;
        val = inflight[best].data;
      end else begin
        pend = 1;
      end
    end
  endtask

  task automatic check_all();
    bit            eh, ep;
    logic [DW-1:0] ev;
    for (int l = 0; l < NL; l++) begin
      for (int j = 0; j < NS; j++) begin
        model_lookup(src[l][j], eh, ep, ev);
        check_eq($sformatf("fwd_hit l%0d s%0d", l, j),
                 DW'(fwd_hit[l*NS+j]), DW'(eh));
        check_eq($sformatf("fwd_pending l%0d s%0d", l, j),
                 DW'(fwd_pending[l*NS+j]), DW'(ep));
        check_eq($sformatf("fwd_data l%0d s%0d", l, j),
                 fwd_data[(l*NS+j)*DW +: DW], ev);
      end
      check_eq($sformatf("wb_en l%0d", l), DW'(wb_en[l]), DW'(exp_wb_en[l]));
      if (exp_wb_en[l]) begin
        check_eq($sformatf("wb_addr l%0d", l), DW'(wb_addr[l*AW +: AW]),
                 DW'(exp_wb_addr[l]));
        check_eq($sformatf("wb_data l%0d", l), wb_data[l*DW +: DW],
                 exp_wb_data[l]);
      end
    end
  endtask

  // Called at a falling edge with inputs already set.
  task automatic tick();
    apply();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  logic [DW-1:0] aa, val_a, val_b, val_x, val_y;

  initial begin
    aa    = {16{8'hAA}};
    val_a = {4{32'h1111_000A}};
    val_b = {4{32'h2222_000B}};
    val_x = {4{32'h3333_000C}};
    val_y = {4{32'h4444_000D}};

    rst = 1'b1;
    idle_inputs();
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset wb_en", DW'(wb_en), '0);
    check_eq("reset wb_addr", DW'(wb_addr), '0);
    check_eq("reset wb_data", wb_data[DW-1:0], '0);
    check_eq("reset fwd_hit", DW'(fwd_hit), '0);
    rst = 1'b0;

    // Latency 2 producer: pending in stage 1, ready in stage 2, writes at 7.
    idle_inputs(); push(0, 7'd5, 2, aa); src[0][0] = 7'd5;
    tick();
    v[0] = 0; apply();
    #1 check_eq("lat2 stage1 pending", DW'(fwd_pending[0]), DW'(PEND_EN));
    check_eq("lat2 stage1 hit", DW'(fwd_hit[0]), DW'(!PEND_EN));
    tick();
    check_eq("lat2 stage2 hit", DW'(fwd_hit[0]), 1);
    check_eq("lat2 stage2 data", fwd_data[DW-1:0], aa);
    repeat (5) tick();
    check_eq("lat2 wb_en", DW'(wb_en[0]), 1);
    check_eq("lat2 wb_addr", DW'(wb_addr[AW-1:0]), 5);

    // Same stage, same dst in both lanes: lane 1 wins.
    idle_inputs(); push(0, 7'd9, 1, val_a); push(1, 7'd9, 1, val_b);
    tick();
    idle_inputs(); src[0][0] = 7'd9; apply();
    #1 check_eq("lane order hit", DW'(fwd_hit[0]), 1);
    check_eq("lane order data", fwd_data[DW-1:0], val_b);
    tick();

    // Younger unready producer shadows an older ready one.
    idle_inputs(); push(0, 7'd3, 1, val_x);
    tick();
    idle_inputs(); push(0, 7'd3, 6, val_y);
    tick();
    idle_inputs(); src[0][1] = 7'd3; apply();
    #1 check_eq("stale pending", DW'(fwd_pending[1]), DW'(PEND_EN));
    check_eq("stale hit", DW'(fwd_hit[1]), DW'(!PEND_EN));
    check_eq("stale data", fwd_data[DW +: DW], PEND_EN ? '0 : val_y);
    tick();

    // Flush kills the entry leaving stage 1; the flush-cycle push survives.
    repeat (8) begin idle_inputs(); tick(); end
    idle_inputs(); push(0, 7'd4, 1, val_a);
    tick();
    idle_inputs(); flush = 1'b1; push(1, 7'd6, 1, val_b); src[1][2] = 7'd4;
    tick();
    idle_inputs(); src[1][2] = 7'd4; apply();
    #1 check_eq("flush r4 hit", DW'(fwd_hit[5]), 0);
    check_eq("flush r4 pending", DW'(fwd_pending[5]), 0);
    repeat (8) begin
      idle_inputs(); src[1][2] = 7'd4; tick();
    end

    // Stall: r7 held at stage 3, inputs and flush ignored, no writeback.
    idle_inputs(); push(0, 7'd7, 1, val_x);
    tick();
    idle_inputs(); tick();
    idle_inputs(); tick();
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); stall = 1'b1; flush = (k == 1);
      push(1, 7'd7, 1, val_y); src[0][2] = 7'd7; apply();
      #1 check_eq($sformatf("stall%0d hit", k), DW'(fwd_hit[2]), 1);
      check_eq($sformatf("stall%0d data", k), fwd_data[2*DW +: DW], val_x);
      check_eq($sformatf("stall%0d wb_en", k), DW'(wb_en), '0);
      tick();
    end
    repeat (4) begin idle_inputs(); src[0][2] = 7'd7; tick(); end
    check_eq("stall release wb_en", DW'(wb_en[0]), 1);
    check_eq("stall release wb_addr", DW'(wb_addr[AW-1:0]), 7);

    // Async reset with five results in flight.
    repeat (8) begin idle_inputs(); tick(); end
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      push(0, AW'(10 + k), 1, val_a);
      if (k < 2) push(1, AW'(20 + k), 1, val_b);
      tick();
    end
    idle_inputs(); src[0][0] = 7'd10; src[0][1] = 7'd11; src[1][0] = 7'd20;
    apply();
    #1 check_eq("pre-rst hit", DW'(fwd_hit[0]), 1);
    #2 rst = 1'b1;
    #1 check_eq("rst hit", DW'(fwd_hit), '0);
    check_eq("rst pending", DW'(fwd_pending), '0);
    check_eq("rst wb_en", DW'(wb_en), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      for (int l = 0; l < NL; l++) begin
        v[l]   = ($urandom_range(0, 3) != 0);
        w[l]   = ($urandom_range(0, 4) != 0);
        d[l]   = AW'($urandom_range(0, 7));
        lt[l]  = LW'($urandom_range(0, 15));
        dat[l] = {$urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < NS; j++) src[l][j] = AW'($urandom_range(0, 8));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
